cic_comp_fir: RTL and testbench

Runtime-programmable FIR filter that sits directly downstream of the CIC decimator. It consumes the decimated `data_out`/`data_out_valid` stream and corrects the CIC passband droop. The CIC output rate is at most one sample per `DECIMATION_RATIO` clocks, so the block uses one time-shared multiplier with a sequential MAC over a circular sample buffer. Its output feeds the demodulation/output stages.

---
 rtl/cic_comp_fir_if.sv | 41 ++++
 rtl/cic_comp_fir.sv | 127 ++++++++++++
 tb/tb_cic_comp_fir.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cic_comp_fir_if.sv
// -----------------------------------------------------------------------------
// cic_comp_fir_if
// Bundles the sample stream, coefficient-write port and status flags of the
// CIC droop-compensation FIR.
//   master : upstream side (drives samples and coefficient writes, observes
//            the filtered output and status flags)
//   slave  : the filter itself
// Signals:
//   data_in / data_in_valid          : decimated CIC sample and its strobe
//   coef_we / coef_addr / coef_data  : coefficient write port
//   data_out / data_out_valid        : filtered sample and its one-cycle pulse
//   busy                             : filter is computing (state != IDLE)
//   overrun                          : sticky, an input arrived while busy
// -----------------------------------------------------------------------------
interface cic_comp_fir_if #(
   parameter int DATA_WIDTH = 12,
   parameter int N_TAPS     = 16,
   parameter int COEF_WIDTH = 12
);
   localparam int ADDR_WIDTH = $clog2(N_TAPS);

   logic signed [DATA_WIDTH-1:0] data_in;
   logic                         data_in_valid;
   logic                         coef_we;
   logic        [ADDR_WIDTH-1:0] coef_addr;
   logic signed [COEF_WIDTH-1:0] coef_data;
   logic signed [DATA_WIDTH-1:0] data_out;
   logic                         data_out_valid;
   logic                         busy;
   logic                         overrun;

   modport master (
      output data_in, data_in_valid, coef_we, coef_addr, coef_data,
      input  data_out, data_out_valid, busy, overrun
   );

   modport slave (
      input  data_in, data_in_valid, coef_we, coef_addr, coef_data,
      output data_out, data_out_valid, busy, overrun
   );
endinterface

// File: rtl/cic_comp_fir.sv
// -----------------------------------------------------------------------------
// cic_comp_fir
// Runtime-programmable FIR that corrects the CIC passband droop. One shared
// multiplier walks the taps sequentially (one tap per clock) over a circular
// sample buffer, then rounds, saturates and registers the result.
// Ports:
//   clk  : single clock, rising edge
//   arst : asynchronous active-high reset (aborts any computation)
//   bus  : cic_comp_fir_if.slave (samples in/out, coefficient writes, status)
// -----------------------------------------------------------------------------
module cic_comp_fir #(
   parameter int DATA_WIDTH = 12,
   parameter int N_TAPS     = 16,
   parameter int COEF_WIDTH = 12
) (
   input  logic          clk,
   input  logic          arst,
   cic_comp_fir_if.slave bus
);
   localparam int ADDR_WIDTH = $clog2(N_TAPS);
   localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
   localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + ADDR_WIDTH;

   localparam logic signed [COEF_WIDTH-1:0] UNITY      = COEF_WIDTH'(2 ** (COEF_WIDTH - 2));
   localparam logic signed [ACC_WIDTH-1:0]  ROUND_BIAS = ACC_WIDTH'(2 ** (COEF_WIDTH - 3));
   localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX    = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN    = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));
   localparam logic        [ADDR_WIDTH-1:0] LAST_TAP   = ADDR_WIDTH'(N_TAPS - 1);

   typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

   state_t state, state_nxt;

   logic signed [DATA_WIDTH-1:0] x [N_TAPS];
   logic signed [COEF_WIDTH-1:0] h [N_TAPS];
   logic        [ADDR_WIDTH-1:0] wp;
   logic        [ADDR_WIDTH-1:0] k;
   logic        [ADDR_WIDTH-1:0] rd_idx;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [PROD_WIDTH-1:0] x_ext, h_ext, prod;
   logic signed [ACC_WIDTH-1:0]  rnd_sum, r;
   logic signed [DATA_WIDTH-1:0] sat_val;

   // wp already points past the newest sample, so the newest slot is wp-1;
   // subtracting k walks the buffer newest-first, wrapping naturally.
   assign rd_idx = wp - ADDR_WIDTH'(1) - k;

   // Sized casts of signed operands sign-extend, giving a full-width product.
   assign x_ext = PROD_WIDTH'(x[rd_idx]);
   assign h_ext = PROD_WIDTH'(h[k]);
   assign prod  = x_ext * h_ext;

   assign bus.busy = (state != IDLE);

   // NOTE: sequential state uses <= so every register samples pre-edge values;
   // blocking = here would make ordering between always_ff blocks matter.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: next-state is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.data_in_valid) state_nxt = MAC;
         MAC:     if (k == LAST_TAP)     state_nxt = SAT;
         SAT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Round half toward +inf, arithmetic shift back to sample scale, clip.
   always_comb begin
      rnd_sum = acc + ROUND_BIAS;
      r       = rnd_sum >>> (COEF_WIDTH - 2);
      if (r > SAT_MAX)      sat_val = DATA_WIDTH'(SAT_MAX);
      else if (r < SAT_MIN) sat_val = DATA_WIDTH'(SAT_MIN);
      else                  sat_val = DATA_WIDTH'(r);
   end

   // NOTE: both arrays are register files with a defined reset image (h[0] =
   // unity makes the filter a pure delay); a RAM macro could not reset them.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < N_TAPS; i++) begin
            x[i] <= '0;
            h[i] <= (i == 0) ? UNITY : '0;
         end
         wp                 <= '0;
         k                  <= '0;
         acc                <= '0;
         bus.data_out       <= '0;
         bus.data_out_valid <= 1'b0;
         bus.overrun        <= 1'b0;
      end else begin
         bus.data_out_valid <= 1'b0;

         // A same-cycle tap read sees the old coefficient; the write lands at
         // this edge.
         if (bus.coef_we) h[bus.coef_addr] <= bus.coef_data;

         if (bus.data_in_valid && (state != IDLE)) bus.overrun <= 1'b1;

         unique case (state)
            IDLE: begin
               if (bus.data_in_valid) begin
                  x[wp] <= bus.data_in;
                  wp    <= wp + ADDR_WIDTH'(1);
                  acc   <= '0;
                  k     <= '0;
               end
            end
            MAC: begin
               acc <= acc + ACC_WIDTH'(prod);
               k   <= k + ADDR_WIDTH'(1);
            end
            SAT: begin
               bus.data_out       <= sat_val;
               bus.data_out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cic_comp_fir.sv
// -----------------------------------------------------------------------------
// tb_cic_comp_fir
// Directed stimulus with hand-computed results. Each accepted input pushes its
// expected output and acceptance cycle into a queue; an independent monitor
// pops and compares value and latency whenever data_out_valid is seen.
// -----------------------------------------------------------------------------
module tb_cic_comp_fir;
   localparam int DW = 12;
   localparam int NT = 16;
   localparam int CW = 12;
   localparam int LATENCY = NT + 1;

   typedef struct {
      int val;
      int cyc0;
   } exp_t;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   int   cyc  = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   cic_comp_fir_if #(.DATA_WIDTH(DW), .N_TAPS(NT), .COEF_WIDTH(CW)) bus ();

   cic_comp_fir #(.DATA_WIDTH(DW), .N_TAPS(NT), .COEF_WIDTH(CW)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!arst && bus.data_out_valid) begin
         check("output_expected", (sb.size() > 0) ? 1 : 0, 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("data_out", bus.data_out, e.val);
            check("latency", cyc - e.cyc0, LATENCY);
         end
      end
   end

   task automatic push_in(input logic signed [DW-1:0] v, output int c0);
      @(negedge clk);
      bus.data_in       = v;
      bus.data_in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.data_in_valid = 1'b0;
      c0 = cyc;
   endtask

   task automatic send(input logic signed [DW-1:0] v, input int exp_val);
      int c0;
      push_in(v, c0);
      sb.push_back('{val: exp_val, cyc0: c0});
   endtask

   task automatic gap();
      repeat (20) @(negedge clk);
   endtask

   task automatic write_coef(input int addr, input int val);
      @(negedge clk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'(addr);
      bus.coef_data = 12'(val);
      @(posedge clk);
      #1;
      bus.coef_we = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      arst = 1'b1;
      repeat (2) @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.busy) done = 1'b1;
      end
      check("drain", done, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1, "watchdog");
   end

   initial begin
      int vals[3] = '{100, -2048, 2047};
      int c_drop;
      int nbusy;

      bus.data_in       = '0;
      bus.data_in_valid = 1'b0;
      bus.coef_we       = 1'b0;
      bus.coef_addr     = '0;
      bus.coef_data     = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data_out", bus.data_out, 0);
      check("rst_valid", bus.data_out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_overrun", bus.overrun, 0);
      arst = 1'b0;

      // Reset coefficients: pure delay, busy for exactly 17 cycles
      foreach (vals[i]) begin
         send(12'(vals[i]), vals[i]);
         nbusy = 0;
         for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
         end
         check("busy_cycles", nbusy, LATENCY);
         repeat (23) @(negedge clk);
      end
      drain();
      check("data_out_hold", bus.data_out, 2047);

      // Impulse response, then wrap: 17th sample pushes the impulse out
      do_reset();
      for (int t = 0; t < NT; t++) write_coef(t, 10 * (t + 1));
      send(12'sd1024, 10);
      gap();
      for (int n = 1; n < NT; n++) begin
         send(12'sd0, 10 * (n + 1));
         gap();
      end
      send(12'sd0, 0);
      drain();

      // Saturation, positive then negative
      do_reset();
      for (int t = 0; t < NT; t++) write_coef(t, 1024);
      send(12'sd2047, 2047);
      gap();
      send(12'sd2047, 2047);
      drain();
      do_reset();
      for (int t = 0; t < NT; t++) write_coef(t, 1024);
      send(-12'sd2048, -2048);
      gap();
      send(-12'sd2048, -2048);
      drain();

      // Rounding: +1.5 -> 2, -1.5 -> -1
      do_reset();
      write_coef(0, 512);
      send(12'sd3, 2);
      gap();
      send(-12'sd3, -1);
      drain();

      // Overrun: second input at E3 dropped, flag sticks
      do_reset();
      send(12'sd5, 5);
      check("overrun_before", bus.overrun, 0);
      repeat (2) @(posedge clk);
      push_in(12'sd9, c_drop);
      check("overrun_set", bus.overrun, 1);
      drain();
      check("overrun_sticky", bus.overrun, 1);
      send(12'sd7, 7);
      drain();
      check("overrun_still", bus.overrun, 1);

      // Reset mid-MAC aborts; coefficients return to unity delay
      do_reset();
      write_coef(0, 2047);
      write_coef(1, 300);
      push_in(12'sd77, c_drop);
      repeat (7) @(posedge clk);
      #1;
      arst = 1'b1;
      #1;
      check("abort_data_out", bus.data_out, 0);
      check("abort_valid", bus.data_out_valid, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_overrun", bus.overrun, 0);
      repeat (2) @(negedge clk);
      arst = 1'b0;
      repeat (30) @(negedge clk);
      send(12'sd77, 77);
      drain();
      check("final_data_out", bus.data_out, 77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
